if_fetch_redirect: RTL and testbench



---
 rtl/if_fetch_redirect.sv | 109 ++++++++++
 tb/tb_if_fetch_redirect.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_redirect.sv
// Instruction-fetch front end: keeps one word fetch outstanding, presents it to decode,
// and parks after any control-flow instruction until the branch unit supplies the next PC.
module if_fetch_redirect #(
    parameter int                ADDR_W   = 32,
    parameter int                WORD_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    output logic              mem_req_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic              mem_ack_in,
    input  logic [WORD_W-1:0] mem_data_in,
    output logic              inst_valid_out,
    output logic [WORD_W-1:0] inst_out,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              id_stall_in,
    input  logic              branch_en_in,
    input  logic [ADDR_W-1:0] branch_dest_in
);

    // state   | meaning
    // REQ     | fetching the word at pc; request becomes visible the cycle after entry
    // HOLD    | fetched word presented to decode, waiting for it to be accepted
    // WAIT_BR | control-flow instruction dispatched, waiting for the resolved next PC
    typedef enum logic [1:0] {REQ, HOLD, WAIT_BR} state_t;

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_d;
    logic [ADDR_W-1:0] addr_d;
    logic              valid_d;
    logic [WORD_W-1:0] inst_d;
    logic [ADDR_W-1:0] pc_out_d;
    logic              is_cf;

    assign is_cf = (inst_out[6:0] == 7'b1100011) ||
                   (inst_out[6:0] == 7'b1101111) ||
                   (inst_out[6:0] == 7'b1100111);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = mem_req_out;
        addr_d   = mem_addr_out;
        valid_d  = inst_valid_out;
        inst_d   = inst_out;
        pc_out_d = pc_out;
        case (state_q)
            REQ: begin
                // An ack only counts once our request is actually on the bus.
                if (mem_req_out && mem_ack_in) begin
                    req_d    = 1'b0;
                    valid_d  = 1'b1;
                    inst_d   = mem_data_in;
                    pc_out_d = pc_q;
                    state_d  = HOLD;
                end else begin
                    req_d  = 1'b1;
                    addr_d = pc_q;
                end
            end
            HOLD: begin
                if (!id_stall_in) begin
                    valid_d = 1'b0;
                    if (is_cf) begin
                        state_d = WAIT_BR;
                    end else begin
                        pc_d    = pc_q + PC_STEP;
                        state_d = REQ;
                    end
                end
            end
            WAIT_BR: begin
                req_d = 1'b0;
                if (branch_en_in) begin
                    pc_d    = branch_dest_in & ALIGN_MASK;
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= REQ;
            pc_q           <= RESET_PC;
            mem_req_out    <= 1'b0;
            mem_addr_out   <= RESET_PC;
            inst_valid_out <= 1'b0;
            inst_out       <= '0;
            pc_out         <= RESET_PC;
        end else if (rdy) begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            mem_req_out    <= req_d;
            mem_addr_out   <= addr_d;
            inst_valid_out <= valid_d;
            inst_out       <= inst_d;
            pc_out         <= pc_out_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_redirect.sv
// Self-checking bench for if_fetch_redirect: directed vector table, reset/rdy corner
// sequences, then randomized instruction streams checked against a PC-level model.
module tb_if_fetch_redirect;

    localparam logic [31:0] RST_PC = 32'h100;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        mem_req_out, mem_ack_in, inst_valid_out, id_stall_in, branch_en_in;
    logic [31:0] mem_addr_out, mem_data_in, inst_out, pc_out, branch_dest_in;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] word;
        int          ack_dly;
        int          stall;
        int          br_wait;
        logic [31:0] dest;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    if_fetch_redirect #(.ADDR_W(32), .WORD_W(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .mem_req_out    (mem_req_out),
        .mem_addr_out   (mem_addr_out),
        .mem_ack_in     (mem_ack_in),
        .mem_data_in    (mem_data_in),
        .inst_valid_out (inst_valid_out),
        .inst_out       (inst_out),
        .pc_out         (pc_out),
        .id_stall_in    (id_stall_in),
        .branch_en_in   (branch_en_in),
        .branch_dest_in (branch_dest_in)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit is_cf(input logic [31:0] w);
        return (w[6:0] == 7'h63) || (w[6:0] == 7'h6F) || (w[6:0] == 7'h67);
    endfunction

    task automatic fetch_and_present(input logic [31:0] addr, input logic [31:0] word,
                                     input int ack_dly);
        int n = 0;
        while (mem_req_out !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("req_seen", mem_req_out, 1);
        chk("req_addr", mem_addr_out, addr);
        for (int i = 0; i < ack_dly; i++) begin
            mem_data_in = $urandom();
            step();
            chk("req_held", mem_req_out, 1);
            chk("addr_held", mem_addr_out, addr);
            chk("no_valid_in_req", inst_valid_out, 0);
        end
        mem_ack_in  = 1'b1;
        mem_data_in = word;
        step();
        mem_ack_in  = 1'b0;
        mem_data_in = $urandom();
        chk("valid", inst_valid_out, 1);
        chk("inst", inst_out, word);
        chk("pc_out", pc_out, addr);
        chk("req_drop", mem_req_out, 0);
    endtask

    task automatic do_fetch(input vec_t v);
        fetch_and_present(v.exp_addr, v.word, v.ack_dly);
        id_stall_in = (v.stall > 0);
        for (int i = 0; i < v.stall; i++) begin
            step();
            chk("stall_valid", inst_valid_out, 1);
            chk("stall_inst", inst_out, v.word);
            chk("stall_pc", pc_out, v.exp_addr);
            chk("stall_no_req", mem_req_out, 0);
        end
        id_stall_in = 1'b0;
        step();
        chk("accept_valid_low", inst_valid_out, 0);
        chk("accept_no_req", mem_req_out, 0);
        if (is_cf(v.word)) begin
            for (int i = 0; i < v.br_wait; i++) begin
                step();
                chk("park_no_req", mem_req_out, 0);
            end
            branch_en_in   = 1'b1;
            branch_dest_in = v.dest;
            step();
            branch_en_in   = 1'b0;
            branch_dest_in = $urandom();
            chk("redir_lat_no_req", mem_req_out, 0);
        end
        step();
        chk("next_req", mem_req_out, 1);
        chk("next_addr", mem_addr_out, v.exp_next);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        logic [31:0] model_pc;
        logic [31:0] r;
        logic [6:0]  ops[5];

        vecs[0] = '{32'h00100013, 2, 0, 0, 32'h0,        32'h100,      32'h104};
        vecs[1] = '{32'h00500093, 2, 3, 0, 32'h0,        32'h104,      32'h108};
        vecs[2] = '{32'h00000013, 2, 0, 0, 32'h0,        32'h108,      32'h10C};
        vecs[3] = '{32'h00208463, 2, 0, 5, 32'h200,      32'h10C,      32'h200};
        vecs[4] = '{32'h0000006F, 1, 1, 2, 32'h110,      32'h200,      32'h110};
        vecs[5] = '{32'h00008067, 0, 0, 0, 32'h203,      32'h110,      32'h200};
        vecs[6] = '{32'h00000013, 3, 2, 0, 32'h0,        32'h200,      32'h204};
        vecs[7] = '{32'h00000067, 1, 0, 1, 32'hFFFFFFFC, 32'h204,      32'hFFFFFFFC};
        vecs[8] = '{32'h00000013, 2, 0, 0, 32'h0,        32'hFFFFFFFC, 32'h0};
        vecs[9] = '{32'h00000013, 2, 0, 0, 32'h0,        32'h0,        32'h4};

        rst = 1'b1; rdy = 1'b1; mem_ack_in = 1'b0; mem_data_in = '0;
        id_stall_in = 1'b0; branch_en_in = 1'b0; branch_dest_in = '0;
        step();
        step();
        chk("rst_req", mem_req_out, 0);
        chk("rst_addr", mem_addr_out, RST_PC);
        chk("rst_valid", inst_valid_out, 0);
        chk("rst_inst", inst_out, 0);
        chk("rst_pc_out", pc_out, RST_PC);
        rst = 1'b0;

        for (int k = 0; k < 10; k++) do_fetch(vecs[k]);

        // rdy low in REQ: ack pulse must be lost, request stays up for a fresh ack
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ack_in  = (i == 1);
            mem_data_in = 32'hDEAD0013;
            step();
            chk("rdy_hold_req", mem_req_out, 1);
            chk("rdy_hold_valid", inst_valid_out, 0);
        end
        mem_ack_in = 1'b0;
        rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rdy_back_req", mem_req_out, 1);
            chk("rdy_back_valid", inst_valid_out, 0);
            chk("rdy_back_addr", mem_addr_out, 32'h4);
        end
        v = '{32'h00400013, 0, 0, 0, 32'h0, 32'h4, 32'h8};
        do_fetch(v);

        // reset while parked in WAIT_BR with a simultaneous redirect
        fetch_and_present(32'h8, 32'h00000063, 1);
        step();
        chk("wb_park", mem_req_out, 0);
        step();
        chk("wb_park2", mem_req_out, 0);
        rst = 1'b1; branch_en_in = 1'b1; branch_dest_in = 32'h300;
        step();
        chk("wbrst_req", mem_req_out, 0);
        chk("wbrst_addr", mem_addr_out, RST_PC);
        chk("wbrst_valid", inst_valid_out, 0);
        chk("wbrst_pc_out", pc_out, RST_PC);
        rst = 1'b0; mem_ack_in = 1'b1; mem_data_in = 32'h00000013;
        step();
        branch_en_in = 1'b0; mem_ack_in = 1'b0;
        chk("postrst_ack_ignored", inst_valid_out, 0);
        chk("postrst_req", mem_req_out, 1);
        chk("postrst_addr", mem_addr_out, RST_PC);
        v = '{32'h00000013, 2, 0, 0, 32'h0, RST_PC, RST_PC + 32'h4};
        do_fetch(v);

        // randomized stream: model only tracks the architectural next PC
        ops = '{7'h13, 7'h63, 7'h6F, 7'h67, 7'h33};
        model_pc = RST_PC + 32'h4;
        for (int k = 0; k < 60; k++) begin
            r = $urandom();
            v.word     = {r[31:7], ops[$urandom_range(0, 4)]};
            v.ack_dly  = $urandom_range(0, 3);
            v.stall    = $urandom_range(0, 3);
            v.br_wait  = $urandom_range(0, 4);
            v.dest     = $urandom();
            v.exp_addr = model_pc;
            v.exp_next = is_cf(v.word) ? (v.dest & 32'hFFFFFFFC) : model_pc + 32'h4;
            do_fetch(v);
            model_pc = v.exp_next;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
